// File: rtl/spi_pkg.sv
// spi_pkg: shared frame layout constants and FSM state type for the SPI master transmitter.
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: 4-deep synchronous command FIFO with wrap-around pointers and occupancy count.
module spi_cmd_fifo
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FRAME_BITS-1:0] wdata,
  output logic [FRAME_BITS-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  logic [FRAME_BITS-1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  assign full = cnt == 3'd4;
  assign empty = cnt == 3'd0;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 2'd1 : wp;
      rp <= pop ? rp + 2'd1 : rp;
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: CPOL=0 SPI master sending {data,addr} 16-bit frames MSB first on SCLK/MOSI/SS.
// Define SPI_TX_FIFO_EN to place a 4-entry command FIFO ahead of the shifter.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [7:0] addr_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  output logic       ss
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, nstate;
  logic [DW-1:0] div_cnt, div_d;
  logic [3:0] bit_cnt, bit_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [FRAME_BITS-1:0] sh, sh_d, frame;
  logic sclk_d, mosi_d, ss_d, done_d, load, div_end, gap_end;
  assign div_end = div_cnt == DW'(CLK_DIV - 1);
  assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
`ifdef SPI_TX_FIFO_EN
  logic full, empty, push, pop;
  logic [FRAME_BITS-1:0] head;
  // An idle request with nothing queued bypasses the FIFO so latency matches the FIFO-less build.
  assign load = (state == IDLE && (!empty || start)) || (state == GAP && gap_end && !empty);
  assign frame = empty ? {data_in, addr_in} : head;
  assign pop = load && !empty;
  assign push = start && !full && !(load && empty);
  assign ready = !full;
  assign busy = state != IDLE || !empty;
  spi_cmd_fifo u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .wdata({data_in, addr_in}), .rdata(head), .full(full), .empty(empty)
  );
`else
  assign load = state == IDLE && start;
  assign frame = {data_in, addr_in};
  assign ready = state == IDLE;
  assign busy = state != IDLE;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = load ? SHIFT : IDLE;
      SHIFT:   nstate = (div_end && sclk && bit_cnt == 4'(FRAME_BITS - 1)) ? HOLD : SHIFT;
      HOLD:    nstate = div_end ? GAP : HOLD;
      GAP:     nstate = gap_end ? (load ? SHIFT : IDLE) : GAP;
      default: nstate = IDLE;
    endcase
  end
  // Next values of every registered output and counter; sclk doubles as the half-bit phase.
  always_comb begin
    sh_d = sh;
    bit_d = bit_cnt;
    div_d = (state == SHIFT || state == HOLD) ? (div_end ? '0 : div_cnt + 1'b1) : '0;
    gap_d = (state == GAP) ? gap_cnt + 1'b1 : '0;
    sclk_d = sclk;
    mosi_d = mosi;
    ss_d = ss;
    done_d = 1'b0;
    if (load) begin
      sh_d = frame;
      bit_d = '0;
      div_d = '0;
      sclk_d = 1'b0;
      mosi_d = frame[FRAME_BITS-1];
      ss_d = 1'b0;
    end else if (state == SHIFT && div_end) begin
      sclk_d = !sclk;
      sh_d = sclk ? sh << 1 : sh;
      bit_d = sclk ? bit_cnt + 4'd1 : bit_cnt;
      mosi_d = sclk ? sh[FRAME_BITS-2] : mosi;
    end else if (state == HOLD && div_end) begin
      ss_d = 1'b1;
      done_d = 1'b1;
      mosi_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      ss <= 1'b1;
      done <= 1'b0;
    end else begin
      sh <= sh_d;
      bit_cnt <= bit_d;
      div_cnt <= div_d;
      gap_cnt <= gap_d;
      sclk <= sclk_d;
      mosi <= mosi_d;
      ss <= ss_d;
      done <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: drives two transmitters (CLK_DIV 4/GAP 4 and 2/1) and checks recovered frames and timing.
module tb_spi_master_tx;
  localparam int CDV[2] = '{4, 2};
  localparam int GCV[2] = '{4, 1};
`ifdef SPI_TX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start, ready, busy, done, sclk, mosi, ss;
  logic [7:0] din[2];
  logic [7:0] ain[2];
  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  int last_rise[2];
  int viol[2];
  logic [15:0] exp_q[2][$];
  int acc_q[2][$];
  logic [15:0] frm_q[2][$];
  int low_q[2][$], nb_q[2][$], fall_q[2][$], fr_q[2][$], rise_q[2][$], done_q[2][$];

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(4), .GAP_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .data_in(din[0]), .addr_in(ain[0]),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .mosi(mosi[0]), .ss(ss[0])
  );
  spi_master_tx #(.CLK_DIV(2), .GAP_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .data_in(din[1]), .addr_in(ain[1]),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .mosi(mosi[1]), .ss(ss[1])
  );

  initial begin
    logic [15:0] rx[2];
    int nb[2], low[2], fall1[2], fr1[2];
    logic [1:0] psclk, pss, pmosi;
    rx = '{16'h0, 16'h0}; nb = '{0, 0}; low = '{0, 0}; fall1 = '{0, 0}; fr1 = '{0, 0};
    psclk = '0; pss = '1; pmosi = '0; viol = '{0, 0};
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          rx[i] = '0; nb[i] = 0; low[i] = 0;
        end else begin
          if (!ss[i]) begin
            low[i]++;
            if (pss[i]) fall1[i] = ncyc;
            else if (mosi[i] !== pmosi[i] && !(psclk[i] && !sclk[i])) viol[i]++;
            if (sclk[i] && !psclk[i]) begin
              rx[i] = {rx[i][14:0], mosi[i]};
              nb[i]++;
              if (nb[i] == 1) fr1[i] = ncyc;
            end
          end else if (!pss[i]) begin
            frm_q[i].push_back(rx[i]); low_q[i].push_back(low[i]); nb_q[i].push_back(nb[i]);
            fall_q[i].push_back(fall1[i]); fr_q[i].push_back(fr1[i]); rise_q[i].push_back(ncyc);
            rx[i] = '0; nb[i] = 0; low[i] = 0;
          end
          if (done[i]) done_q[i].push_back(ncyc);
        end
        psclk[i] = sclk[i]; pss[i] = ss[i]; pmosi[i] = mosi[i];
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [7:0] a);
    int w = 0;
    start[i] = 1'b1; din[i] = d; ain[i] = a;
    while (!ready[i] && w < 3000) begin step(1); w++; end
    tests++; if (w >= 3000) begin fails++; $error("FAIL ready_wait: got %0d", w); end
    exp_q[i].push_back({d, a});
    acc_q[i].push_back(ncyc);
    step(1);
  endtask

  task automatic verify(input int i);
    int w, n, a, l, b, fl, r1, r, dn, ef;
    logic [15:0] e, f;
    w = 0;
    while (done_q[i].size() < exp_q[i].size() && w < 6000) begin step(1); w++; end
    step(8);
    tests++; if (frm_q[i].size() !== exp_q[i].size()) begin fails++; $error("FAIL frame_count: got %0d expected %0d", frm_q[i].size(), exp_q[i].size()); end
    tests++; if (done_q[i].size() !== exp_q[i].size()) begin fails++; $error("FAIL done_count: got %0d expected %0d", done_q[i].size(), exp_q[i].size()); end
    n = exp_q[i].size();
    if (frm_q[i].size() < n) n = frm_q[i].size();
    if (done_q[i].size() < n) n = done_q[i].size();
    for (int k = 0; k < n; k++) begin
      e = exp_q[i].pop_front(); a = acc_q[i].pop_front(); f = frm_q[i].pop_front();
      l = low_q[i].pop_front(); b = nb_q[i].pop_front(); fl = fall_q[i].pop_front();
      r1 = fr_q[i].pop_front(); r = rise_q[i].pop_front(); dn = done_q[i].pop_front();
      ef = FIFO ? ((a + 1 > last_rise[i] + GCV[i]) ? a + 1 : last_rise[i] + GCV[i]) : a + 1;
      tests++; if (f[15:8] !== e[15:8]) begin fails++; $error("FAIL slave_data: got %0h expected %0h", f[15:8], e[15:8]); end
      tests++; if (f[7:0] !== e[7:0]) begin fails++; $error("FAIL slave_addr: got %0h expected %0h", f[7:0], e[7:0]); end
      tests++; if (l !== 33 * CDV[i]) begin fails++; $error("FAIL ss_low_cycles: got %0d expected %0d", l, 33 * CDV[i]); end
      tests++; if (b !== 16) begin fails++; $error("FAIL sclk_rises: got %0d expected 16", b); end
      tests++; if (fl !== ef) begin fails++; $error("FAIL ss_fall_cycle: got %0d expected %0d", fl, ef); end
      tests++; if (r1 - fl !== CDV[i]) begin fails++; $error("FAIL first_sclk_rise: got %0d expected %0d", r1 - fl, CDV[i]); end
      tests++; if (dn !== r) begin fails++; $error("FAIL done_at_ss_rise: got %0d expected %0d", dn, r); end
      last_rise[i] = r;
    end
    tests++; if (viol[i] !== 0) begin fails++; $error("FAIL mosi_stable: got %0d expected 0", viol[i]); end
    exp_q[i].delete(); acc_q[i].delete(); frm_q[i].delete(); low_q[i].delete(); nb_q[i].delete();
    fall_q[i].delete(); fr_q[i].delete(); rise_q[i].delete(); done_q[i].delete();
  endtask

  initial begin
    rst_n = 1'b0; start = '0; din = '{8'h0, 8'h0}; ain = '{8'h0, 8'h0};
    last_rise = '{-1000, -1000};
    step(3);
    for (int i = 0; i < 2; i++) begin
      tests++; if (ss[i] !== 1'b1) begin fails++; $error("FAIL rst_ss: got %0h", ss[i]); end
      tests++; if (sclk[i] !== 1'b0) begin fails++; $error("FAIL rst_sclk: got %0h", sclk[i]); end
      tests++; if (mosi[i] !== 1'b0) begin fails++; $error("FAIL rst_mosi: got %0h", mosi[i]); end
      tests++; if (ready[i] !== 1'b1) begin fails++; $error("FAIL rst_ready: got %0h", ready[i]); end
      tests++; if (busy[i] !== 1'b0) begin fails++; $error("FAIL rst_busy: got %0h", busy[i]); end
      tests++; if (done[i] !== 1'b0) begin fails++; $error("FAIL rst_done: got %0h", done[i]); end
    end
    rst_n = 1'b1;
    step(1);
    send(0, 8'hA5, 8'h3C);
    start[0] = 1'b0;
    tests++; if (ss[0] !== 1'b0) begin fails++; $error("FAIL t1_ss: got %0h", ss[0]); end
    tests++; if (mosi[0] !== 1'b1) begin fails++; $error("FAIL t1_mosi: got %0h", mosi[0]); end
    tests++; if (sclk[0] !== 1'b0) begin fails++; $error("FAIL t1_sclk: got %0h", sclk[0]); end
    tests++; if (busy[0] !== 1'b1) begin fails++; $error("FAIL t1_busy: got %0h", busy[0]); end
    tests++; if (ready[0] !== FIFO) begin fails++; $error("FAIL t1_ready: got %0h expected %0h", ready[0], FIFO); end
    verify(0);
    send(0, 8'h01, 8'h02);
    send(0, 8'h03, 8'h04);
    start[0] = 1'b0;
`ifndef SPI_TX_FIFO_EN
    tests++; if (acc_q[0][1] - acc_q[0][0] !== 33 * 4 + 4 + 1) begin fails++; $error("FAIL b2b_accept_spacing: got %0d", acc_q[0][1] - acc_q[0][0]); end
`endif
    verify(0);
`ifndef SPI_TX_FIFO_EN
    send(0, 8'h11, 8'h22);
    start[0] = 1'b0;
    step(49);
    start[0] = 1'b1; din[0] = 8'hFF; ain[0] = 8'hFF;
    step(1);
    start[0] = 1'b0;
    verify(0);
    step(150);
    tests++; if (done_q[0].size() !== 0) begin fails++; $error("FAIL ignored_start_no_frame: got %0d", done_q[0].size()); end
`endif
    send(0, 8'h77, 8'h88);
    start[0] = 1'b0;
    exp_q[0].delete(); acc_q[0].delete();
    step(59);
    rst_n = 1'b0;
    #1;
    tests++; if (ss[0] !== 1'b1) begin fails++; $error("FAIL midrst_ss: got %0h", ss[0]); end
    tests++; if (sclk[0] !== 1'b0) begin fails++; $error("FAIL midrst_sclk: got %0h", sclk[0]); end
    tests++; if (mosi[0] !== 1'b0) begin fails++; $error("FAIL midrst_mosi: got %0h", mosi[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $error("FAIL midrst_busy: got %0h", busy[0]); end
    step(2);
    rst_n = 1'b1;
    tests++; if (done_q[0].size() !== 0) begin fails++; $error("FAIL midrst_no_done: got %0d", done_q[0].size()); end
    tests++; if (frm_q[0].size() !== 0) begin fails++; $error("FAIL midrst_no_frame: got %0d", frm_q[0].size()); end
    last_rise[0] = -1000;
    send(0, 8'h55, 8'hAA);
    start[0] = 1'b0;
    verify(0);
    for (int k = 0; k < 5; k++) send(0, 8'($urandom), 8'($urandom));
`ifdef SPI_TX_FIFO_EN
    tests++; if (ready[0] !== 1'b0) begin fails++; $error("FAIL fifo_full_ready: got %0h", ready[0]); end
`endif
    start[0] = 1'b0;
    verify(0);
    send(1, 8'h3C, 8'h5A);
    start[1] = 1'b0;
    verify(1);
    send(1, 8'($urandom), 8'($urandom));
    send(1, 8'($urandom), 8'($urandom));
    start[1] = 1'b0;
`ifndef SPI_TX_FIFO_EN
    tests++; if (acc_q[1][1] - acc_q[1][0] !== 68) begin fails++; $error("FAIL sweep_period: got %0d expected 68", acc_q[1][1] - acc_q[1][0]); end
`endif
    verify(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
